toggle_event_decoder: RTL and testbench
=======================================

Name: toggle_event_decoder

Overview:
- Receive-side decoder for toggle-encoded event signalling. The transmitter's T flip-flop flips its Q once per event, and this block turns each flip back into one counted event.
- Sits in the destination clock domain.
- Synchronises the toggle line, detects transitions and queues them in a saturating pending counter.
- Presents the queue to the consumer through a valid/ready handshake, and keeps a free-running total-event counter.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on t_in; legal range 2..4.
- PEND_W, 4, width of the pending-event counter; it saturates at 2^PEND_W-1.
- TOTAL_W, 16, width of the total-event counter; it wraps.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears all state.
- t_in  input  1  toggle line from a remote T flip-flop Q; may be asynchronous to clk.
- event_pulse  output  1  one-cycle strobe for each detected toggle.
- ev_valid  output  1  high while at least one event is pending.
- ev_ready  input  1  consumer accepts one event on any cycle where ev_valid && ev_ready.
- pending  output  PEND_W  current pending-event count.
- total_count  output  TOTAL_W  number of events detected since reset, modulo 2^TOTAL_W.
- overflow  output  1  sticky flag: an event was lost because the pending counter was saturated.
- clr_overflow  input  1  synchronous clear of overflow.
- armed  output  1  high once the post-reset fill phase is complete.

Behaviour:
- Reset: sync chain, prev, pending, total_count, overflow, armed and the fill counter all go to 0; state=FILL.
- Outputs during reset: event_pulse=0, ev_valid=0.
- Synchroniser: sync[0] samples t_in each clk; sync[i] samples sync[i-1].
- Transition detect: prev samples sync[SYNC_STAGES-1] every cycle; raw_edge = sync[SYNC_STAGES-1] ^ prev.
- FSM state FILL:
  - prev tracks the synchroniser output, and raw_edge is ignored.
  - The fill counter runs for SYNC_STAGES+1 cycles, then the FSM moves to RUN and armed=1.
  - Purpose: a t_in level already present at reset release never produces a spurious event.
- FSM state RUN: event_pulse = raw_edge, asserted combinationally from registers.
- FSM has no other transitions; only reset returns it to FILL.
- Latency: a t_in change that settles before clk edge k produces event_pulse high in the cycle after edge k+SYNC_STAGES-1.
- total_count and pending update at edge k+SYNC_STAGES.
- ev_valid = (pending != 0), a registered-value compare; it is low in FILL.
- Pending update (pop = ev_valid && ev_ready):
  - event and no pop: +1, unless saturated.
  - pop and no event: -1.
  - event and pop together: unchanged.
  - neither: unchanged.
  - ev_ready while pending==0 has no effect.
- Saturation: an event arriving while pending==max and with no pop in the same cycle is dropped from pending. It still increments total_count, and overflow is set the next cycle.
- Overflow clear: clr_overflow clears overflow. If an overflow-causing event occurs in the same cycle, the set wins.
- total_count wraps from 2^TOTAL_W-1 to 0 with no flag.
- Double toggles: two t_in toggles closer than one clk period may merge into none. This is a documented protocol limit: the transmitter must hold each level for at least 2 destination clk periods.
- Reset mid-operation: pending events are discarded, counters are zeroed, and the block re-enters FILL.

Decomposition:
- Shared package event_pkg: state enum (FILL, RUN) and the SYNC_STAGES default constant.
- One sub-module, sync_chain: parameterised N-flop synchroniser with asynchronous reset. It is reusable by other clock-domain-crossing blocks.
- FSM, counters and handshake stay in the top module.

Test Plan:
- Hold t_in=1 through reset release, then idle 10 cycles -> armed=1 after 3 cycles, event_pulse never asserts, pending=0, total_count=0.
- After armed, toggle t_in 0->1 once, ev_ready=0 -> event_pulse high for exactly one cycle 2 cycles after the change, then pending=1, ev_valid=1, total_count=1.
- Toggle 20 times, at least 3 cycles apart, with ev_ready=0 (PEND_W=4) -> pending stops at 15, overflow=1, total_count=20. Then clr_overflow for 1 cycle -> overflow=0.
- Hold ev_ready=1 while toggling every 3 cycles, 8 times -> each event is popped in the cycle after it enters, pending never exceeds 1, total_count=8, overflow=0.
- With pending=5, apply a toggle so its event lands on a cycle with ev_valid && ev_ready -> pending stays 5 for that cycle.
- Assert reset asynchronously mid-cycle with pending=7 -> all outputs 0 immediately, armed=0; after release, FILL lasts 3 cycles before new toggles are counted.

Source files
------------

// File: rtl/event_pkg.sv
// Shared types and defaults for the toggle event decoder.
// Imported by the top module and the bench.
package event_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/toggle_event_decoder_if.sv
// Consumer handshake for queued toggle events.
// master drives valid/pending, slave drives ready.
interface toggle_event_decoder_if #(
  parameter int PEND_W = 4
);

  logic              ev_valid;
  logic              ev_ready;
  logic [PEND_W-1:0] pending;

  modport master (
    output ev_valid,
    output pending,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  pending,
    output ev_ready
  );

endinterface

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous bit.
// Reusable by any clock-domain-crossing block.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // shift the input one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // synchroniser flops, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Turns each flip of a remote toggle line into one queued event.
// Fill phase after reset masks any level already present on t_in.
module toggle_event_decoder
  import event_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int PEND_W      = 4,
  parameter int TOTAL_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               t_in,
  output logic               event_pulse,
  output logic [TOTAL_W-1:0] total_count,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic               armed,
  toggle_event_decoder_if.master ev_if
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               prev_q, prev_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [TOTAL_W-1:0] tot_q, tot_d;
  logic               ovf_q, ovf_d;
  logic               sync_out;
  logic               raw_edge;
  logic               ev;
  logic               pop;
  logic               ovf_set;

  sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (t_in),
    .q     (sync_out)
  );

  assign raw_edge = sync_out ^ prev_q;
  assign pop      = ev_if.ev_valid && ev_if.ev_ready;

  // fsm, edge qualification, pending queue and counters
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    prev_d  = sync_out;
    pend_d  = pend_q;
    tot_d   = tot_q;
    ovf_d   = ovf_q;
    ev      = 1'b0;
    ovf_set = 1'b0;
    unique case (state_q)
      FILL: begin
        fill_d = fill_q + FILL_W'(1);
        if (fill_q == FILL_W'(SYNC_STAGES)) state_d = RUN;
      end
      RUN: ev = raw_edge;
    endcase
    tot_d = tot_q + TOTAL_W'(ev);
    if (ev && !pop) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + PEND_W'(1);
      else                    ovf_set = 1'b1;
    end else if (pop && !ev) begin
      pend_d = pend_q - PEND_W'(1);
    end
    if (ovf_set)           ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  // state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      pend_q  <= '0;
      tot_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      tot_q   <= tot_d;
      ovf_q   <= ovf_d;
    end
  end

  assign event_pulse    = ev;
  assign total_count    = tot_q;
  assign overflow       = ovf_q;
  assign armed          = (state_q == RUN);
  assign ev_if.pending  = pend_q;
  assign ev_if.ev_valid = (pend_q != '0);

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder.
// Each toggle queues its expected pulse cycle and total.
module tb_toggle_event_decoder;
  import event_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] tot;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_in;
  logic        event_pulse;
  logic [15:0] total_count;
  logic        overflow;
  logic        clr_overflow;
  logic        armed;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_total = 0;
  int   max_pend;
  exp_t q[$];

  toggle_event_decoder_if #(.PEND_W(4)) ev_if ();

  toggle_event_decoder #(
    .SYNC_STAGES (2),
    .PEND_W      (4),
    .TOTAL_W     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .t_in         (t_in),
    .event_pulse  (event_pulse),
    .total_count  (total_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .armed        (armed),
    .ev_if        (ev_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle();
    exp_t e;
    t_in = ~t_in;
    e.cyc = cyc + 2;
    e.tot = exp_total[15:0];
    q.push_back(e);
    exp_total++;
  endtask

  // monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse at expected cycle %0d",
               q[0].cyc);
      void'(q.pop_front());
    end
    if (event_pulse === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse: pulse at cycle %0d, expected none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_total", int'(total_count), int'(e.tot));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    t_in         = 1'b1;
    ev_if.ev_ready = 1'b0;
    clr_overflow = 1'b0;
    tick(3);
    chk("rst_pulse", int'(event_pulse), 0);
    chk("rst_valid", int'(ev_if.ev_valid), 0);
    chk("rst_pending", int'(ev_if.pending), 0);
    chk("rst_total", int'(total_count), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_ovf", int'(overflow), 0);

    // release with t_in already high: no spurious event
    reset = 1'b0;
    tick(2);
    chk("fill_armed_lo", int'(armed), 0);
    tick(1);
    chk("fill_armed_hi", int'(armed), 1);
    tick(7);
    chk("idle_pending", int'(ev_if.pending), 0);
    chk("idle_total", int'(total_count), 0);

    // single toggle
    toggle();
    tick(3);
    chk("one_pending", int'(ev_if.pending), 1);
    chk("one_valid", int'(ev_if.ev_valid), 1);
    chk("one_total", int'(total_count), 1);

    // saturate: 1 + 20 events into a 15-deep counter
    for (int i = 0; i < 20; i++) begin
      toggle();
      tick(3);
    end
    chk("sat_pending", int'(ev_if.pending), 15);
    chk("sat_total", int'(total_count), 21);
    chk("sat_ovf", int'(overflow), 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_pending", int'(ev_if.pending), 15);

    // drain one per cycle
    ev_if.ev_ready = 1'b1;
    tick(15);
    ev_if.ev_ready = 1'b0;
    chk("drain_pending", int'(ev_if.pending), 0);
    chk("drain_valid", int'(ev_if.ev_valid), 0);

    // consumer always ready
    ev_if.ev_ready = 1'b1;
    max_pend = 0;
    for (int i = 0; i < 8; i++) begin
      toggle();
      for (int k = 0; k < 3; k++) begin
        tick(1);
        if (int'(ev_if.pending) > max_pend) max_pend = int'(ev_if.pending);
      end
    end
    tick(2);
    ev_if.ev_ready = 1'b0;
    chk("rdy_max_pending", max_pend, 1);
    chk("rdy_total", int'(total_count), 29);
    chk("rdy_ovf", int'(overflow), 0);
    chk("rdy_pending", int'(ev_if.pending), 0);

    // event and pop in the same cycle
    for (int i = 0; i < 5; i++) begin
      toggle();
      tick(3);
    end
    chk("five_pending", int'(ev_if.pending), 5);
    toggle();
    tick(2);
    chk("pre_both_pending", int'(ev_if.pending), 5);
    ev_if.ev_ready = 1'b1;
    tick(1);
    ev_if.ev_ready = 1'b0;
    chk("both_pending", int'(ev_if.pending), 5);
    chk("both_total", int'(total_count), 35);

    // build pending to 7, then reset mid-cycle
    for (int i = 0; i < 2; i++) begin
      toggle();
      tick(3);
    end
    chk("seven_pending", int'(ev_if.pending), 7);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_pending", int'(ev_if.pending), 0);
    chk("mid_rst_valid", int'(ev_if.ev_valid), 0);
    chk("mid_rst_total", int'(total_count), 0);
    chk("mid_rst_armed", int'(armed), 0);
    chk("mid_rst_pulse", int'(event_pulse), 0);
    tick(2);
    exp_total = 0;

    // toggle during fill must be ignored
    reset = 1'b0;
    t_in  = ~t_in;
    tick(2);
    chk("refill_armed_lo", int'(armed), 0);
    tick(1);
    chk("refill_armed_hi", int'(armed), 1);
    tick(3);
    chk("refill_total", int'(total_count), 0);
    toggle();
    tick(3);
    chk("post_total", int'(total_count), 1);
    chk("post_pending", int'(ev_if.pending), 1);

    tick(4);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time limit reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
